// File: rtl/dds_serial_rx.sv
// dds_serial_rx
// Receive side of the DDS serial load interface. The block samples the DDS
// pins on clk_sys and follows the DDS reset and serial-mode entry sequence.
// It shifts in each DDS word LSB first and publishes the decoded fields on
// every fq_ud update. It serves as an on-chip loopback checker and as the DDS
// emulator in system benches.
//
// Word layout (bit 0 is received first):
//   [31:0]  frequency tuning word
//   [33:32] control bits
//   [34]    power-down
//   [39:35] phase word
module dds_serial_rx #(
  parameter int WORD_BITS = 40
) (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic        dds_reset,
  input  logic        dds_w_clk,
  input  logic        dds_fq_ud,
  input  logic        dds_data,
  output logic [31:0] freq_word,
  output logic [1:0]  ctrl_bits,
  output logic        pwr_down,
  output logic [4:0]  phase_word,
  output logic        word_valid,
  output logic        frame_err,
  output logic        overrun,
  output logic        serial_mode
);

  // The counter must be able to hold the full-word value WORD_BITS itself.
  localparam int CNT_W = $clog2(WORD_BITS + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WORD_BITS);
  localparam logic [CNT_W-1:0] ZERO_CNT = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE_CNT  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_WCLK = 2'd1,
    ST_WAIT_FQUD = 2'd2,
    ST_SERIAL    = 2'd3
  } state_t;

  state_t               state_r;
  state_t               state_nx_s;
  logic [WORD_BITS-1:0] shift_r;
  logic [WORD_BITS-1:0] shift_nx_s;
  logic [CNT_W-1:0]     count_r;
  logic [CNT_W-1:0]     count_nx_s;
  logic [CNT_W-1:0]     count_mid_s;
  logic                 wclk_q_r;
  logic                 fqud_q_r;
  logic                 overrun_r;
  logic                 overrun_nx_s;
  logic                 load_s;
  logic                 err_s;
  logic                 wclk_edge_s;
  logic                 fqud_edge_s;

  logic [31:0]          freq_r;
  logic [1:0]           ctrl_r;
  logic                 pd_r;
  logic [4:0]           phase_r;
  logic                 word_valid_r;
  logic                 frame_err_r;
  logic                 serial_mode_r;

  // A held pin creates only one edge. A rising edge is the pin high while the
  // previous sample was low.
  assign wclk_edge_s = dds_w_clk & ~wclk_q_r;
  assign fqud_edge_s = dds_fq_ud & ~fqud_q_r;

  // Next state, shift and count. In SERIAL, a w_clk edge in the same cycle as
  // an fq_ud edge is shifted in first, and fq_ud then checks the updated count.
  always_comb begin
    state_nx_s   = state_r;
    shift_nx_s   = shift_r;
    count_nx_s   = count_r;
    count_mid_s  = count_r;
    overrun_nx_s = overrun_r;
    load_s       = 1'b0;
    err_s        = 1'b0;

    if (dds_reset) begin
      state_nx_s   = ST_WAIT_WCLK;
      shift_nx_s   = {WORD_BITS{1'b0}};
      count_nx_s   = ZERO_CNT;
      overrun_nx_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nx_s = ST_IDLE;
        end
        ST_WAIT_WCLK: begin
          // Parallel mode is unsupported, so fq_ud is ignored in this state.
          if (wclk_edge_s) begin
            state_nx_s = ST_WAIT_FQUD;
          end else begin
            state_nx_s = ST_WAIT_WCLK;
          end
        end
        ST_WAIT_FQUD: begin
          if (fqud_edge_s) begin
            state_nx_s = ST_SERIAL;
            count_nx_s = ZERO_CNT;
          end else begin
            state_nx_s = ST_WAIT_FQUD;
          end
        end
        ST_SERIAL: begin
          if (wclk_edge_s) begin
            if (count_r < FULL_CNT) begin
              shift_nx_s  = {dds_data, shift_r[WORD_BITS-1:1]};
              count_mid_s = count_r + ONE_CNT;
            end else begin
              // The word is already full, so the bit is dropped.
              overrun_nx_s = 1'b1;
            end
          end else begin
            count_mid_s = count_r;
          end
          count_nx_s = count_mid_s;
          if (fqud_edge_s) begin
            if (count_mid_s == FULL_CNT) begin
              load_s = 1'b1;
            end else begin
              err_s = 1'b1;
            end
            count_nx_s   = ZERO_CNT;
            overrun_nx_s = 1'b0;
          end else begin
            err_s = 1'b0;
          end
        end
        default: begin
          state_nx_s = ST_IDLE;
        end
      endcase
    end
  end

  // Control state, shift register, counter, pin history and status pulses.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      shift_r       <= {WORD_BITS{1'b0}};
      count_r       <= ZERO_CNT;
      wclk_q_r      <= 1'b0;
      fqud_q_r      <= 1'b0;
      overrun_r     <= 1'b0;
      word_valid_r  <= 1'b0;
      frame_err_r   <= 1'b0;
      serial_mode_r <= 1'b0;
    end else begin
      state_r       <= state_nx_s;
      shift_r       <= shift_nx_s;
      count_r       <= count_nx_s;
      wclk_q_r      <= dds_w_clk;
      fqud_q_r      <= dds_fq_ud;
      overrun_r     <= overrun_nx_s;
      word_valid_r  <= load_s;
      frame_err_r   <= err_s;
      serial_mode_r <= (state_nx_s == ST_SERIAL);
    end
  end

  // Decoded field outputs. They load only on an accepted word and otherwise
  // hold, including through dds_reset.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      freq_r  <= 32'h0000_0000;
      ctrl_r  <= 2'b00;
      pd_r    <= 1'b0;
      phase_r <= 5'd0;
    end else if (load_s) begin
      freq_r  <= shift_nx_s[31:0];
      ctrl_r  <= shift_nx_s[33:32];
      pd_r    <= shift_nx_s[34];
      phase_r <= shift_nx_s[39:35];
    end else begin
      freq_r  <= freq_r;
      ctrl_r  <= ctrl_r;
      pd_r    <= pd_r;
      phase_r <= phase_r;
    end
  end

  assign freq_word   = freq_r;
  assign ctrl_bits   = ctrl_r;
  assign pwr_down    = pd_r;
  assign phase_word  = phase_r;
  assign word_valid  = word_valid_r;
  assign frame_err   = frame_err_r;
  assign overrun     = overrun_r;
  assign serial_mode = serial_mode_r;

endmodule

// File: tb/tb_dds_serial_rx.sv
// tb_dds_serial_rx
// Drives DDS pin sequences into dds_serial_rx. Each fq_ud that should produce
// a pulse pushes the expected outcome into a queue. A monitor on the falling
// edge pops the queue on every word_valid/frame_err pulse and compares. Any
// pulse that arrives with nothing queued counts as an error.
module tb_dds_serial_rx;

  logic        clk_sys = 1'b0;
  logic        rst = 1'b1;
  logic        dds_reset = 1'b0;
  logic        dds_w_clk = 1'b0;
  logic        dds_fq_ud = 1'b0;
  logic        dds_data = 1'b0;
  logic [31:0] freq_word;
  logic [1:0]  ctrl_bits;
  logic        pwr_down;
  logic [4:0]  phase_word;
  logic        word_valid;
  logic        frame_err;
  logic        overrun;
  logic        serial_mode;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        is_valid;
    logic [31:0] freq;
    logic [1:0]  ctrl;
    logic        pd;
    logic [4:0]  phase;
  } exp_t;

  typedef struct {
    int          nbits;
    logic [39:0] word;
    logic        exp_valid;
    logic [31:0] exp_freq;
    logic [1:0]  exp_ctrl;
    logic        exp_pd;
    logic [4:0]  exp_phase;
  } vec_t;

  exp_t exp_q[$];
  exp_t mon_e;
  vec_t vecs[6];

  dds_serial_rx #(.WORD_BITS(40)) dut (
    .clk_sys     (clk_sys),
    .rst         (rst),
    .dds_reset   (dds_reset),
    .dds_w_clk   (dds_w_clk),
    .dds_fq_ud   (dds_fq_ud),
    .dds_data    (dds_data),
    .freq_word   (freq_word),
    .ctrl_bits   (ctrl_bits),
    .pwr_down    (pwr_down),
    .phase_word  (phase_word),
    .word_valid  (word_valid),
    .frame_err   (frame_err),
    .overrun     (overrun),
    .serial_mode (serial_mode)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic send_bit(input logic b, input int hold);
    dds_data  = b;
    dds_w_clk = 1'b1;
    repeat (hold) tick();
    dds_w_clk = 1'b0;
    tick();
  endtask

  task automatic pulse_fqud();
    dds_fq_ud = 1'b1;
    tick();
    dds_fq_ud = 1'b0;
    tick();
  endtask

  task automatic pulse_dds_reset();
    dds_reset = 1'b1;
    tick();
    dds_reset = 1'b0;
    tick();
  endtask

  task automatic expect_pulse(input logic v, input logic [31:0] f, input logic [1:0] c,
                              input logic p, input logic [4:0] ph);
    exp_t e;
    e.is_valid = v;
    e.freq     = f;
    e.ctrl     = c;
    e.pd       = p;
    e.phase    = ph;
    exp_q.push_back(e);
  endtask

  task automatic send_word(input logic [39:0] w, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      send_bit((i < 40) ? w[i] : 1'b1, 1);
    end
  endtask

  task automatic mode_select();
    send_bit(1'b0, 1);
    check("serial_mode_before_fqud", {63'd0, serial_mode}, 64'd0);
    dds_fq_ud = 1'b1;
    tick();
    check("serial_mode_after_fqud", {63'd0, serial_mode}, 64'd1);
    dds_fq_ud = 1'b0;
    tick();
  endtask

  // Scoreboard monitor: every status pulse must match the oldest expectation.
  always @(negedge clk_sys) begin
    if (word_valid || frame_err) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {62'd0, word_valid, frame_err}, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("word_valid", {63'd0, word_valid}, {63'd0, mon_e.is_valid});
        check("frame_err", {63'd0, frame_err}, {63'd0, ~mon_e.is_valid});
        check("freq_word", {32'd0, freq_word}, {32'd0, mon_e.freq});
        check("ctrl_bits", {62'd0, ctrl_bits}, {62'd0, mon_e.ctrl});
        check("pwr_down", {63'd0, pwr_down}, {63'd0, mon_e.pd});
        check("phase_word", {59'd0, phase_word}, {59'd0, mon_e.phase});
      end
    end
  end

  initial begin
    vecs[0] = '{40, {5'h00, 1'b0, 2'b00, 32'h1234ABCD}, 1'b1, 32'h1234ABCD, 2'b00, 1'b0, 5'h00};
    vecs[1] = '{40, {5'h1F, 1'b1, 2'b00, 32'h00000001}, 1'b1, 32'h00000001, 2'b00, 1'b1, 5'h1F};
    vecs[2] = '{39, {5'h0C, 1'b0, 2'b11, 32'h55AA55AA}, 1'b0, 32'h00000001, 2'b00, 1'b1, 5'h1F};
    vecs[3] = '{40, {5'h0A, 1'b0, 2'b10, 32'hDEADBEEF}, 1'b1, 32'hDEADBEEF, 2'b10, 1'b0, 5'h0A};
    vecs[4] = '{41, {5'h15, 1'b1, 2'b01, 32'h0F0F0F0F}, 1'b1, 32'h0F0F0F0F, 2'b01, 1'b1, 5'h15};
    vecs[5] = '{0,  {40'h00_0000_0000},                 1'b0, 32'h0F0F0F0F, 2'b01, 1'b1, 5'h15};

    // Reset state
    repeat (3) tick();
    check("rst_freq", {32'd0, freq_word}, 64'd0);
    check("rst_flags", {58'd0, word_valid, frame_err, overrun, serial_mode, pwr_down, 1'b0}, 64'd0);
    rst = 1'b0;
    tick();

    // Pulses before dds_reset are ignored (IDLE).
    send_bit(1'b1, 1);
    pulse_fqud();
    check("idle_serial_mode", {63'd0, serial_mode}, 64'd0);

    pulse_dds_reset();
    mode_select();

    // Table-driven words in SERIAL.
    for (int r = 0; r < 6; r++) begin
      if (r == 3) begin
        // A w_clk held high for several cycles still counts as one bit.
        send_bit(vecs[r].word[0], 5);
        for (int i = 1; i < vecs[r].nbits; i++) send_bit(vecs[r].word[i], 1);
      end else begin
        send_word(vecs[r].word, vecs[r].nbits);
      end
      check("overrun_before_fqud", {63'd0, overrun}, (vecs[r].nbits > 40) ? 64'd1 : 64'd0);
      expect_pulse(vecs[r].exp_valid, vecs[r].exp_freq, vecs[r].exp_ctrl,
                   vecs[r].exp_pd, vecs[r].exp_phase);
      pulse_fqud();
      check("overrun_after_fqud", {63'd0, overrun}, 64'd0);
      check("serial_mode_row", {63'd0, serial_mode}, 64'd1);
    end

    // dds_reset mid-word: back to WAIT_WCLK with the fields held.
    send_word(40'hFF_FFFF_FFFF, 20);
    pulse_dds_reset();
    check("dreset_serial_mode", {63'd0, serial_mode}, 64'd0);
    check("dreset_freq_held", {32'd0, freq_word}, 64'h0F0F0F0F);
    check("dreset_phase_held", {59'd0, phase_word}, 64'h15);
    pulse_fqud();
    check("dreset_fqud_ignored", {63'd0, serial_mode}, 64'd0);
    mode_select();
    send_word({5'h03, 1'b0, 2'b11, 32'hCAFEF00D}, 40);
    expect_pulse(1'b1, 32'hCAFEF00D, 2'b11, 1'b0, 5'h03);
    pulse_fqud();

    // rst mid-word clears everything and the receiver waits for dds_reset.
    send_word(40'hA5_A5A5_A5A5, 20);
    rst = 1'b1;
    tick();
    check("rst_mid_freq", {32'd0, freq_word}, 64'd0);
    check("rst_mid_fields", {56'd0, ctrl_bits, pwr_down, phase_word}, 64'd0);
    check("rst_mid_flags", {60'd0, word_valid, frame_err, overrun, serial_mode}, 64'd0);
    rst = 1'b0;
    tick();
    send_bit(1'b0, 1);
    pulse_fqud();
    send_word({5'h07, 1'b1, 2'b01, 32'h11112222}, 40);
    pulse_fqud();
    check("rst_idle_serial_mode", {63'd0, serial_mode}, 64'd0);
    check("rst_idle_freq", {32'd0, freq_word}, 64'd0);
    pulse_dds_reset();
    mode_select();
    send_word({5'h07, 1'b1, 2'b01, 32'h11112222}, 40);
    expect_pulse(1'b1, 32'h11112222, 2'b01, 1'b1, 5'h07);
    pulse_fqud();

    repeat (4) tick();
    check("pending_expectations", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dds_serial_rx.md
Name: dds_serial_rx

Overview:
- Receive-side model of the DDS serial load interface; the opposite end of the DDS loader state machine.
- Samples the DDS pins (reset, w_clk, fq_ud, data) on clk_sys, tracks reset and serial-mode entry, and shifts in the 40-bit DDS word LSB first.
- Presents the word as decoded fields on each fq_ud update.
- Used as an on-chip loopback checker and as the DDS emulator in system benches.

Parameters:
- WORD_BITS, 40, number of serial bits per DDS word; bits 0-31 frequency, 32-33 control, 34 power-down, 35-39 phase.

Ports:
- clk_sys      input   1   system clock; all logic is on its rising edge
- rst          input   1   synchronous reset, active high
- dds_reset    input   1   DDS reset pin, synchronous to clk_sys
- dds_w_clk    input   1   DDS word clock pin
- dds_fq_ud    input   1   DDS frequency-update pin
- dds_data     input   1   DDS serial data pin (D7)
- freq_word    output  32  last accepted frequency tuning word
- ctrl_bits    output  2   last accepted control bits (word bits 33:32)
- pwr_down     output  1   last accepted power-down bit (word bit 34)
- phase_word   output  5   last accepted phase word (word bits 39:35)
- word_valid   output  1   one-cycle pulse: outputs updated with a complete word
- frame_err    output  1   one-cycle pulse: fq_ud seen in SERIAL with bit count not equal to 40
- overrun      output  1   sticky: a w_clk edge arrived with 40 bits already held; cleared by rst, dds_reset or any fq_ud edge
- serial_mode  output  1   high while the state is SERIAL

Behaviour:
- Edge detection: register wclk_q and fqud_q from the previous cycle.
  - A w_clk edge is a cycle with dds_w_clk=1 and wclk_q=0.
  - An fq_ud edge is a cycle with dds_fq_ud=1 and fqud_q=0.
  - The captured bit is dds_data in the same cycle as the w_clk edge.
- rst=1 (priority over everything):
  - State goes to IDLE.
  - Shift register, bit counter, wclk_q, fqud_q, all outputs and overrun clear to 0.
- dds_reset=1 in any cycle with rst=0:
  - State goes to WAIT_WCLK.
  - Bit counter and shift register clear; overrun clears.
  - No pulses are produced.
  - freq_word, ctrl_bits, pwr_down and phase_word hold their values.
  - Takes priority over w_clk and fq_ud edges in the same cycle.
- States: IDLE, WAIT_WCLK, WAIT_FQUD, SERIAL.
  - IDLE: ignore w_clk and fq_ud; leave only via dds_reset.
  - WAIT_WCLK: a w_clk edge (data ignored) moves to WAIT_FQUD. An fq_ud edge is ignored and the state stays (parallel mode is unsupported).
  - WAIT_FQUD: an fq_ud edge moves to SERIAL with the counter at 0. Further w_clk edges are ignored and the state stays.
  - SERIAL, w_clk edge with count<40: shift right with the new bit into bit 39, then count+1. After 40 bits, the first bit received sits in bit 0.
  - SERIAL, w_clk edge with count=40: the bit is discarded, overrun sets, and the count stays 40.
  - SERIAL, fq_ud edge with count=40: on the next cycle word_valid=1 and all four field outputs load from the shift register.
  - SERIAL, fq_ud edge with count not equal to 40: on the next cycle frame_err=1 and the field outputs hold.
  - After any SERIAL fq_ud edge: count clears, overrun clears, and the state stays SERIAL ready for the next word. There is no re-reset.
- Same-cycle w_clk and fq_ud edges in SERIAL: the bit is taken first, then fq_ud is evaluated against the incremented count.
- Latency:
  - word_valid and frame_err are registered and assert exactly 1 cycle after the fq_ud edge cycle.
  - serial_mode rises 1 cycle after the fq_ud edge in WAIT_FQUD.
- Held levels: pins held high for many cycles create only one edge each. Back-to-back edges need the pin low for at least 1 cycle between them.

Test Plan:
- Reset sequence, then mode-select pulses (w_clk, then fq_ud), then 40 bits encoding freq=0x1234ABCD, ctrl=0, pd=0, phase=0, then fq_ud -> word_valid pulses once; freq_word=0x1234ABCD, phase_word=0, serial_mode=1.
- Second word without dds_reset: freq=0x00000001, phase=5'h1F, pd=1 -> word_valid; freq_word=1, phase_word=0x1F, pwr_down=1.
- In SERIAL, 39 bits then fq_ud -> frame_err one cycle; freq_word keeps the previous value; the next full 40-bit word is accepted.
- 41 bits then fq_ud -> overrun=1 after bit 41; word_valid with the first 40 bits; overrun clears on the fq_ud edge.
- dds_reset asserted after 20 bits -> state WAIT_WCLK, serial_mode=0, no pulses, fields held. A following fq_ud edge alone is ignored. A complete mode select plus word is then accepted.
- rst asserted mid-word -> all outputs 0 the next cycle. Pulses are ignored until dds_reset is seen.
